// File: rtl/line_window_ctrl.sv
// line_window_ctrl
//   Rolling K+1 line store feeding K x K pixel windows to a convolution engine.
//   Pixels arrive as a raster stream; once K full lines are held, the read
//   side emits IMG_W windows (one per column) over the oldest K lines, then
//   releases the oldest line. Columns past the right image edge read as 0.
//
// Ports
//   clk, rst   clock, asynchronous active-high reset
//   i_sof      synchronous frame restart (one-cycle pulse, highest priority)
//   i_data     input pixel, DATA_W bits
//   i_valid    input pixel valid
//   i_ready    input pixel may be accepted (low while all K+1 stores are full)
//   o_data     K*K*DATA_W window; row r (0 = oldest), column j at
//              bits [(r*K+j)*DATA_W +: DATA_W]
//   o_valid    window valid (registered)
//   o_ready    downstream accepts window
//   o_intr     one-cycle pulse per completed output line
//   o_lines    count of full, unreleased lines (0..K+1)
module line_window_ctrl #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 512,
   parameter int K      = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_sof,
   input  logic [DATA_W-1:0]           i_data,
   input  logic                        i_valid,
   output logic                        i_ready,
   output logic [K*K*DATA_W-1:0]       o_data,
   output logic                        o_valid,
   input  logic                        o_ready,
   output logic                        o_intr,
   output logic [$clog2(K+2)-1:0]      o_lines
);

   localparam int CW = $clog2(IMG_W);
   localparam int BW = $clog2(K+1);
   localparam int LW = $clog2(K+2);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W-1);
   localparam logic [BW-1:0] BUF_LAST = BW'(K);

   typedef enum logic {S_IDLE, S_RD} state_t;

   // Line stores; contents survive reset and frame restart.
   logic [DATA_W-1:0] mem [K+1][IMG_W];

   state_t             state;
   logic [CW-1:0]      wr_col, rd_col, ld_col;
   logic [BW-1:0]      wr_buf, rd_base;
   logic               wr_acc, wr_last, rd_acc, rd_last;
   logic               mem_we;
   logic [BW-1:0]      mem_wb;
   logic [CW-1:0]      mem_wc;
   logic [K*K*DATA_W-1:0] win;

   // With at most K lines in use by the reader, the store at wr_buf is never
   // one the current window references, so fullness is the only write gate.
   assign i_ready = (o_lines != LW'(K+1));
   assign wr_acc  = i_valid & i_ready;
   assign wr_last = wr_acc & (wr_col == COL_LAST);
   assign rd_acc  = (state == S_RD) & o_valid & o_ready;
   assign rd_last = rd_acc & (rd_col == COL_LAST);

   // A frame restart with a pixel present lands it at column 0 of store 0.
   assign mem_we = i_sof ? i_valid : wr_acc;
   assign mem_wb = i_sof ? '0 : wr_buf;
   assign mem_wc = i_sof ? '0 : wr_col;

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_wb][mem_wc] <= i_data;
   end

   // Column of the window loaded into the output register this cycle:
   // the current column on the first load, the next one on each accept.
   assign ld_col = o_valid ? rd_col + CW'(1) : rd_col;

   always_comb begin
      int b;
      int c;
      b   = 0;
      c   = 0;
      win = '0;
      for (int r = 0; r < K; r++) begin
         for (int j = 0; j < K; j++) begin
            b = int'(rd_base) + r;
            if (b > K) b = b - (K+1);
            c = int'(ld_col) + j;
            if (c < IMG_W)
               win[(r*K+j)*DATA_W +: DATA_W] = mem[b[BW-1:0]][c[CW-1:0]];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         wr_col  <= '0;
         wr_buf  <= '0;
         rd_col  <= '0;
         rd_base <= '0;
         o_lines <= '0;
         o_valid <= 1'b0;
         o_intr  <= 1'b0;
         o_data  <= '0;
      end else if (i_sof) begin
         state   <= S_IDLE;
         wr_col  <= i_valid ? CW'(1) : '0;
         wr_buf  <= '0;
         rd_col  <= '0;
         rd_base <= '0;
         o_lines <= '0;
         o_valid <= 1'b0;
         o_intr  <= 1'b0;
         o_data  <= '0;
      end else begin
         o_intr <= rd_last;

         if (wr_acc) begin
            if (wr_last) begin
               wr_col <= '0;
               wr_buf <= (wr_buf == BUF_LAST) ? '0 : wr_buf + BW'(1);
            end else begin
               wr_col <= wr_col + CW'(1);
            end
         end

         // Line complete and line release in the same cycle cancel out.
         if (wr_last && !rd_last)      o_lines <= o_lines + LW'(1);
         else if (rd_last && !wr_last) o_lines <= o_lines - LW'(1);

         case (state)
            S_IDLE: begin
               if (o_lines >= LW'(K)) state <= S_RD;
            end
            S_RD: begin
               if (rd_last) begin
                  state   <= S_IDLE;
                  o_valid <= 1'b0;
                  rd_col  <= '0;
                  rd_base <= (rd_base == BUF_LAST) ? '0 : rd_base + BW'(1);
               end else if (!o_valid) begin
                  o_data  <= win;
                  o_valid <= 1'b1;
               end else if (o_ready) begin
                  o_data  <= win;
                  rd_col  <= rd_col + CW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_line_window_ctrl.sv
// Bench for line_window_ctrl with IMG_W=8, K=3. Stimulus records every
// accepted pixel into a line model and pushes the expected windows of each
// read pass into a scoreboard; a negedge monitor pops and compares them on
// every output handshake. Directed checks cover reset, backpressure, edge
// padding, simultaneous write/release, frame restart and mid-read reset.
module tb_line_window_ctrl;
   localparam int DW = 8;
   localparam int IW = 8;
   localparam int KK = 3;
   localparam int WW = KK*KK*DW;
   localparam int LW = $clog2(KK+2);

   logic          clk = 1'b0;
   logic          rst, i_sof, i_valid, i_ready, o_valid, o_ready, o_intr;
   logic [DW-1:0] i_data;
   logic [WW-1:0] o_data;
   logic [LW-1:0] o_lines;

   always #5 clk = ~clk;

   line_window_ctrl #(.DATA_W(DW), .IMG_W(IW), .K(KK)) dut (
      .clk(clk), .rst(rst), .i_sof(i_sof), .i_data(i_data), .i_valid(i_valid),
      .i_ready(i_ready), .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready),
      .o_intr(o_intr), .o_lines(o_lines)
   );

   typedef struct {
      logic [WW-1:0] data;
      int            line;
      int            col;
   } exp_t;

   exp_t          sb[$];
   exp_t          mon_e;
   int            checks = 0;
   int            failures = 0;
   int            intr_cnt = 0;
   int            i0;
   logic [DW-1:0] mline [0:15][0:IW-1];
   int            m_line = 0, m_col = 0, m_pass = 0;

   task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Hand-written window: a..c = oldest row cols 0..2, d..f middle, g..k newest.
   function automatic logic [WW-1:0] w3(input logic [7:0] a, b, c, d, e, f, g, h, k);
      return {k, h, g, f, e, d, c, b, a};
   endfunction

   function automatic logic [WW-1:0] model_win(input int ln, input int col);
      logic [WW-1:0] w;
      w = '0;
      for (int r = 0; r < KK; r++)
         for (int j = 0; j < KK; j++)
            if (col + j < IW) w[(r*KK+j)*DW +: DW] = mline[ln+r][col+j];
      return w;
   endfunction

   task automatic push_pass(input int ln);
      exp_t e;
      for (int c = 0; c < IW; c++) begin
         e.data = model_win(ln, c);
         e.line = ln;
         e.col  = c;
         sb.push_back(e);
      end
   endtask

   task automatic record_px(input logic [DW-1:0] v);
      mline[m_line][m_col] = v;
      m_col++;
      if (m_col == IW) begin
         m_col = 0;
         m_line++;
         if (m_line >= m_pass + KK) begin
            push_pass(m_pass);
            m_pass++;
         end
      end
   endtask

   task automatic model_reset();
      m_line = 0;
      m_col  = 0;
      m_pass = 0;
      sb.delete();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_px(input logic [DW-1:0] v);
      int n;
      n = 0;
      i_valid = 1'b1;
      i_data  = v;
      while (!i_ready && n < 200) begin
         tick();
         n++;
      end
      if (!i_ready) chk("i_ready_timeout", i_ready, 1);
      else begin
         tick();
         record_px(v);
      end
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!o_valid && n < 100) begin
         tick();
         n++;
      end
      if (!o_valid) chk("o_valid_timeout", o_valid, 1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         tick();
         n++;
      end
      repeat (3) tick();
      chk("drain_empty", sb.size(), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   always @(negedge clk) begin
      if (o_intr) intr_cnt++;
      if (!rst && o_valid && o_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_window: got %0h expected none", o_data);
         end else begin
            mon_e = sb.pop_front();
            chk($sformatf("win_l%0d_c%0d", mon_e.line, mon_e.col), o_data, mon_e.data);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; i_sof = 1'b0; i_valid = 1'b0; i_data = '0; o_ready = 1'b1;
      tick(); tick();
      chk("rst_o_valid", o_valid, 0);
      chk("rst_o_intr",  o_intr, 0);
      chk("rst_o_data",  o_data, 0);
      chk("rst_o_lines", o_lines, 0);
      chk("rst_i_ready", i_ready, 1);
      rst = 1'b0;
      tick();

      // Fill three lines with o_ready high; one pass of 8 windows follows.
      i0 = intr_cnt;
      for (int p = 0; p < 24; p++) send_px(8'(p));
      i_valid = 1'b0;
      chk("s1_lines3", o_lines, 3);
      wait_valid();
      chk("s1_first_win", o_data, w3(0, 1, 2, 8, 9, 10, 16, 17, 18));
      repeat (6) tick();
      chk("s1_col6_pad", o_data, w3(6, 7, 0, 14, 15, 0, 22, 23, 0));
      drain();
      chk("s1_lines2", o_lines, 2);
      chk("s1_intr", intr_cnt - i0, 1);

      // Backpressure: four lines fill all stores while the window is frozen.
      do_reset();
      o_ready = 1'b0;
      for (int p = 0; p < 32; p++) send_px(8'(p));
      i_valid = 1'b0;
      chk("s2_i_ready_low", i_ready, 0);
      chk("s2_lines4", o_lines, 4);
      chk("s2_valid", o_valid, 1);
      chk("s2_frozen0", o_data, w3(0, 1, 2, 8, 9, 10, 16, 17, 18));
      repeat (5) tick();
      chk("s2_frozen1", o_data, w3(0, 1, 2, 8, 9, 10, 16, 17, 18));
      o_ready = 1'b1;
      for (int i = 0; i < IW; i++) begin
         chk($sformatf("s2_burst%0d", i), o_valid, 1);
         tick();
      end
      chk("s2_lines3", o_lines, 3);
      chk("s2_i_ready_high", i_ready, 1);
      drain();
      chk("s2_lines2", o_lines, 2);

      // Stall five cycles on column 3 of the pass over lines 2..4.
      o_ready = 1'b0;
      for (int p = 32; p < 40; p++) send_px(8'(p));
      i_valid = 1'b0;
      wait_valid();
      o_ready = 1'b1;
      repeat (3) tick();
      o_ready = 1'b0;
      chk("s3_col3", o_data, w3(19, 20, 21, 27, 28, 29, 35, 36, 37));
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("s3_hold%0d", i), o_data, w3(19, 20, 21, 27, 28, 29, 35, 36, 37));
      end
      o_ready = 1'b1;
      tick();
      chk("s3_col4", o_data, w3(20, 21, 22, 28, 29, 30, 36, 37, 38));
      drain();
      chk("s3_lines2", o_lines, 2);

      // Line 6 completes on the same edge that releases line 3.
      i0 = intr_cnt;
      o_ready = 1'b0;
      for (int p = 40; p < 55; p++) send_px(8'(p));
      i_valid = 1'b0;
      wait_valid();
      o_ready = 1'b1;
      repeat (7) tick();
      chk("s4_last_col", o_data, w3(31, 0, 0, 39, 0, 0, 47, 0, 0));
      chk("s4_i_ready", i_ready, 1);
      i_valid = 1'b1;
      i_data  = 8'd55;
      tick();
      record_px(8'd55);
      i_valid = 1'b0;
      chk("s4_lines_same", o_lines, 3);
      chk("s4_released", o_valid, 0);
      wait_valid();
      chk("s4_next_rows", o_data, w3(32, 33, 34, 40, 41, 42, 48, 49, 50));
      drain();
      chk("s4_lines2", o_lines, 2);
      chk("s4_intr", intr_cnt - i0, 2);

      // Frame restart at column 5 of line 2 carrying a pixel.
      do_reset();
      o_ready = 1'b0;
      for (int i = 0; i < 21; i++) send_px(8'(100 + i));
      i_sof   = 1'b1;
      i_valid = 1'b1;
      i_data  = 8'hAA;
      model_reset();
      tick();
      record_px(8'hAA);
      i_sof   = 1'b0;
      i_valid = 1'b0;
      chk("s5_lines0", o_lines, 0);
      chk("s5_valid0", o_valid, 0);
      for (int i = 0; i < 24; i++) send_px(8'(150 + i));
      i_valid = 1'b0;
      wait_valid();
      chk("s5_sof_win", o_data, w3(8'hAA, 150, 151, 157, 158, 159, 165, 166, 167));
      chk("s5_lines3", o_lines, 3);

      // Reset while a window is pending, then refill.
      i0  = intr_cnt;
      rst = 1'b1;
      model_reset();
      #1;
      chk("s6_async_valid", o_valid, 0);
      chk("s6_async_lines", o_lines, 0);
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("s6_no_intr", intr_cnt - i0, 0);
      o_ready = 1'b1;
      for (int p = 0; p < 24; p++) send_px(8'(p));
      i_valid = 1'b0;
      wait_valid();
      chk("s6_first_win", o_data, w3(0, 1, 2, 8, 9, 10, 16, 17, 18));
      drain();
      chk("s6_lines2", o_lines, 2);
      chk("s6_intr", intr_cnt - i0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
